// File: rtl/usb_tx_packet_encoder.sv
// usb_tx_packet_encoder
//   Full-speed USB transmit stage. Turns one-cycle handshake strobes into
//   ACK / NAK packets and a nonce request into a DATA1 packet
//   (4 nonce bytes + CRC16). The serial stream is SYNC, PID, payload and
//   CRC, bit-stuffed and NRZI-encoded, followed by SE0-SE0-J EOP.
//
// Ports
//   clk, n_rst      : clock, asynchronous active-low reset
//   transmit_ack    : strobe, send ACK   (PID 0xD2)
//   transmit_nack   : strobe, send NAK   (PID 0x5A), highest priority
//   send_nonce      : strobe, send DATA1 (PID 0x4B) + nonce + CRC16
//   nonce[31:0]     : payload, captured in the accept cycle, byte 0 first
//   d_plus, d_minus : registered bus lines (idle J = 1/0)
//   tx_busy         : high from the cycle after accept through tx_done
//   tx_done         : one-cycle pulse at the end of the packet
module usb_tx_packet_encoder #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        transmit_ack,
    input  logic        transmit_nack,
    input  logic        send_nonce,
    input  logic [31:0] nonce,
    output logic        d_plus,
    output logic        d_minus,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam int              TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]   TMAX      = TW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]      SYNC      = 8'h80;
    localparam logic [7:0]      PID_ACK   = 8'hD2;
    localparam logic [7:0]      PID_NAK   = 8'h5A;
    localparam logic [7:0]      PID_DATA1 = 8'h4B;
    localparam logic [15:0]     CRC_POLY  = 16'h8005;

    typedef enum logic [2:0] {
        IDLE, SHIFT, STUFF, EOP_SE0, EOP_J, DONE
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer;
    logic [5:0]    bit_idx;     // index of the data bit currently on the line
    logic [2:0]    ones_cnt;    // consecutive 1s in the unstuffed stream
    logic          eop_cnt;     // which SE0 bit time we are in
    logic          lvl;         // NRZI level, 1 = J
    logic          is_data;
    logic [7:0]    pid_q;
    logic [31:0]   nonce_q;
    logic [15:0]   crc;

    logic          accept, wrap, last_bit, stuff_now;
    logic          send_data, send_stuff, se0_start, j_start, crc_upd;
    logic [5:0]    nxt_idx;
    logic [4:0]    noff;
    logic          nxt_bit, crc_fb;

    assign accept    = (state == IDLE) & (transmit_ack | transmit_nack | send_nonce);
    assign wrap      = (timer == TMAX);
    assign last_bit  = (bit_idx == (is_data ? 6'd63 : 6'd15));
    assign stuff_now = (ones_cnt == 3'd6);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_n;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = SHIFT;
            SHIFT:   if (wrap) begin
                         if (stuff_now)     state_n = STUFF;
                         else if (last_bit) state_n = EOP_SE0;
                     end
            STUFF:   if (wrap) state_n = last_bit ? EOP_SE0 : SHIFT;
            EOP_SE0: if (wrap && eop_cnt) state_n = EOP_J;
            EOP_J:   if (wrap) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        tx_busy    = (state != IDLE);
        tx_done    = (state == DONE);
        // Stuffing is checked before end-of-packet so a trailing run of six
        // 1s in the CRC still gets its stuffed 0 ahead of EOP.
        send_data  = accept |
                     (wrap & ((state == SHIFT) & ~stuff_now & ~last_bit)) |
                     (wrap & ((state == STUFF) & ~last_bit));
        send_stuff = (state == SHIFT) & wrap & stuff_now;
        se0_start  = wrap & last_bit &
                     (((state == SHIFT) & ~stuff_now) | (state == STUFF));
        j_start    = (state == EOP_SE0) & wrap & eop_cnt;
    end

    // Bit source: SYNC, PID, nonce (16..47), then complemented CRC MSB first.
    // For 48..63 the low nibble counts up, so its inverse walks crc[15]..crc[0].
    always_comb begin
        nxt_idx = accept ? 6'd0 : bit_idx + 6'd1;
        noff    = nxt_idx[4:0] - 5'd16;
        if (nxt_idx < 6'd8)       nxt_bit = SYNC[nxt_idx[2:0]];
        else if (nxt_idx < 6'd16) nxt_bit = pid_q[nxt_idx[2:0]];
        else if (nxt_idx < 6'd48) nxt_bit = nonce_q[noff];
        else                      nxt_bit = ~crc[~nxt_idx[3:0]];
        crc_upd = send_data & ~accept & (nxt_idx >= 6'd16) & (nxt_idx < 6'd48);
        crc_fb  = nxt_bit ^ crc[15];
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer    <= '0;
            bit_idx  <= '0;
            ones_cnt <= '0;
            eop_cnt  <= 1'b0;
            lvl      <= 1'b1;
            is_data  <= 1'b0;
            pid_q    <= '0;
            nonce_q  <= '0;
            crc      <= 16'hFFFF;
            d_plus   <= 1'b1;
            d_minus  <= 1'b0;
        end else begin
            if (accept) begin
                pid_q   <= transmit_nack ? PID_NAK : (transmit_ack ? PID_ACK : PID_DATA1);
                is_data <= ~transmit_nack & ~transmit_ack;
                nonce_q <= nonce;
                crc     <= 16'hFFFF;
                timer   <= '0;
            end else if (state inside {SHIFT, STUFF, EOP_SE0, EOP_J}) begin
                timer   <= wrap ? '0 : timer + TW'(1);
            end

            if (send_data) begin
                bit_idx  <= nxt_idx;
                ones_cnt <= nxt_bit ? ones_cnt + 3'd1 : 3'd0;
                if (!nxt_bit) lvl <= ~lvl;
                d_plus   <= nxt_bit ? lvl : ~lvl;
                d_minus  <= nxt_bit ? ~lvl : lvl;
                if (crc_upd) crc <= {crc[14:0], 1'b0} ^ (crc_fb ? CRC_POLY : 16'h0000);
            end else if (send_stuff) begin
                ones_cnt <= 3'd0;
                lvl      <= ~lvl;
                d_plus   <= ~lvl;
                d_minus  <= lvl;
            end else if (se0_start) begin
                eop_cnt  <= 1'b0;
                d_plus   <= 1'b0;
                d_minus  <= 1'b0;
            end else if (j_start) begin
                lvl      <= 1'b1;
                d_plus   <= 1'b1;
                d_minus  <= 1'b0;
            end else if ((state == EOP_SE0) && wrap) begin
                eop_cnt  <= 1'b1;
            end
        end
    end

endmodule
